// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the multi-port integer register file.
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int DEPTH_DEF = 32;

  function automatic int rf_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register plus an incrementally kept
// popcount. An issue (set) and a long-latency writeback (clear) may land together.
module reg_scoreboard
  import rf_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = rf_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_ni,
  input  logic             set_en_i,
  input  logic [AW-1:0]    set_addr_i,
  input  logic             clr_en_i,
  input  logic [AW-1:0]    clr_addr_i,
  output logic [DEPTH-1:0] pend_o,
  output logic [AW:0]      cnt_o
);

  logic [DEPTH-1:0] pend_q, pend_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             set_hit;
  logic             inc;
  logic             dec;

  always_comb begin
    set_hit = set_en_i && (set_addr_i != '0);
    pend_d  = pend_q;
    if (clr_en_i) pend_d[clr_addr_i] = 1'b0;
    // Set is applied after clear so a same-edge set on the same address wins.
    if (set_hit) pend_d[set_addr_i] = 1'b1;

    inc = set_hit && !pend_q[set_addr_i];
    dec = clr_en_i && pend_q[clr_addr_i] && !(set_hit && (set_addr_i == clr_addr_i));

    cnt_d = cnt_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (dec && !inc) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_o = pend_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with two write ports, optional same-cycle
// forwarding and a pending-write scoreboard for long-latency results.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  parameter  int NUM_RD = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = rf_aw(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_ni,
  input  logic [NUM_RD*AW-1:0]   rd_addr_i,
  output logic [NUM_RD*XLEN-1:0] rd_data_o,
  output logic [NUM_RD-1:0]      rd_busy_o,
  input  logic                   wp0_en_i,
  input  logic [AW-1:0]          wp0_addr_i,
  input  logic [XLEN-1:0]        wp0_data_i,
  input  logic                   wp1_en_i,
  input  logic [AW-1:0]          wp1_addr_i,
  input  logic [XLEN-1:0]        wp1_data_i,
  input  logic                   issue_en_i,
  input  logic [AW-1:0]          issue_addr_i,
  output logic                   wr_conflict_o,
  output logic [AW:0]            pend_cnt_o
);

  logic [XLEN-1:0]  regs_q [DEPTH];
  logic [XLEN-1:0]  regs_d [DEPTH];
  logic             wr_conflict_q, wr_conflict_d;
  logic [DEPTH-1:0] pend;
  logic [AW:0]      pend_cnt;
  logic             wp0_live;
  logic             wp1_live;

  assign wp0_live = wp0_en_i && (wp0_addr_i != '0);
  assign wp1_live = wp1_en_i && (wp1_addr_i != '0);

  // WP0 is applied last so it overrides WP1 on a shared address.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (wp1_live && (wp1_addr_i == AW'(i))) regs_d[i] = wp1_data_i;
      if (wp0_live && (wp0_addr_i == AW'(i))) regs_d[i] = wp0_data_i;
    end
    regs_d[0]     = '0;
    wr_conflict_d = wp0_live && wp1_en_i && (wp0_addr_i == wp1_addr_i);
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  reg_scoreboard #(
    .DEPTH (DEPTH)
  ) u_sb (
    .clk        (clk),
    .reset_ni   (reset_ni),
    .set_en_i   (issue_en_i),
    .set_addr_i (issue_addr_i),
    .clr_en_i   (wp1_en_i),
    .clr_addr_i (wp1_addr_i),
    .pend_o     (pend),
    .cnt_o      (pend_cnt)
  );

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;

    assign addr = rd_addr_i[gi*AW +: AW];

    always_comb begin
      data = regs_q[addr];
      busy = pend[addr];
      if ((BYPASS != 0) && (addr != '0)) begin
        if (wp0_en_i && (wp0_addr_i == addr)) begin
          data = wp0_data_i;
        end else if (wp1_en_i && (wp1_addr_i == addr)) begin
          data = wp1_data_i;
        end
        if (wp1_en_i && (wp1_addr_i == addr)) busy = 1'b0;
      end
      if (!reset_ni) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd_data_o[gi*XLEN +: XLEN] = data;
    assign rd_busy_o[gi]              = busy;
  end

  assign wr_conflict_o = wr_conflict_q;
  assign pend_cnt_o    = pend_cnt;

endmodule
